// File: rtl/mul_acc_unsigned.sv
// mul_acc_unsigned: sums LEN consecutive unsigned products from the multiplier
// into one result, presented on a held valid/ready output with overflow flag.
// Optional build macro: MUL_ACC_SAT_EN (clamp accumulator on overflow instead
// of wrapping).
module mul_acc_unsigned #(
  parameter int WIDTH     = 4,
  parameter int LEN       = 4,
  parameter int ACC_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   z_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 ovf,
  output logic [7:0]           cnt
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  state_t               state, state_nxt;
  logic                 accept, release_hold;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;

  // One extra bit catches the carry out of the accumulator width.
  assign sum = {1'b0, acc} + (ACC_WIDTH+1)'(z_in);

`ifdef MUL_ACC_SAT_EN
  // Clamp on carry; once at the ceiling any further nonzero add carries again,
  // so the value stays pinned for the rest of the group.
  assign acc_nxt = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  // Plain modulo 2^ACC_WIDTH wrap.
  assign acc_nxt = sum[ACC_WIDTH-1:0];
`endif

  assign acc_out = acc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next state and handshake decode; outputs depend only on registered state.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    accept       = 1'b0;
    release_hold = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && cnt == LAST_CNT) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid    = 1'b1;
        release_hold = out_ready;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulator, product count and sticky overflow; cleared on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (release_hold) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= cnt + 8'd1;
      ovf <= ovf | sum[ACC_WIDTH];
    end
  end

endmodule

// File: tb/tb_mul_acc_unsigned.sv
// Directed bench for mul_acc_unsigned: two instances (ACC_WIDTH 10 and 9) driven
// in lockstep, results checked against a scoreboard filled by a small model.
module tb_mul_acc_unsigned;
  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] z_in = '0;

  logic       ir_a, ov_a, ovf_a, ir_b, ov_b, ovf_b;
  logic [9:0] acc_a;
  logic [8:0] acc_b;
  logic [7:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  mul_acc_unsigned #(.WIDTH(4), .LEN(LEN), .ACC_WIDTH(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .z_in(z_in),
    .out_valid(ov_a), .out_ready(out_ready), .acc_out(acc_a), .ovf(ovf_a), .cnt(cnt_a)
  );

  mul_acc_unsigned #(.WIDTH(4), .LEN(LEN), .ACC_WIDTH(9)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .z_in(z_in),
    .out_valid(ov_b), .out_ready(out_ready), .acc_out(acc_b), .ovf(ovf_b), .cnt(cnt_b)
  );

  typedef struct {int acc; bit ovf;} exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$], qb[$];
  int   ma_acc, mb_acc, m_cnt;
  bit   ma_ovf, mb_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_add(inout int acc, inout bit ovf, input int z, input int aw);
    int tsum, maxv;
    maxv = (1 << aw) - 1;
    tsum = acc + z;
    if (tsum > maxv) begin
      ovf = 1'b1;
`ifdef MUL_ACC_SAT_EN
      acc = maxv;
`else
      acc = tsum & maxv;
`endif
    end else begin
      acc = tsum;
    end
  endfunction

  task automatic model_reset();
    ma_acc = 0; mb_acc = 0; ma_ovf = 0; mb_ovf = 0; m_cnt = 0;
  endtask

  // Offer one product after 'gap' idle cycles; the accept happens on the
  // rising edge following return.
  task automatic send(input int z, input int gap);
    int n;
    repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
    @(negedge clk);
    in_valid = 1'b1;
    z_in     = 8'(z);
    n = 0;
    while (!ir_a && n < 50) begin @(negedge clk); n++; end
    chk("send_timeout", 32'(n < 50), 1);
    chk("in_ready_b", ir_b, 1);
    chk("cnt_accum", cnt_a, m_cnt);
    model_add(ma_acc, ma_ovf, z, 10);
    model_add(mb_acc, mb_ovf, z, 9);
    m_cnt++;
    if (m_cnt == LEN) begin
      qa.push_back('{ma_acc, ma_ovf});
      qb.push_back('{mb_acc, mb_ovf});
      model_reset();
    end
  endtask

  // Wait for a result, compare against the scoreboard, hold it 'stall' cycles
  // with optional in_valid pressure, then release and check the cleared state.
  task automatic get(input int stall, input bit hold_valid);
    exp_t ea, eb;
    int   n;
    @(negedge clk);
    in_valid = hold_valid;
    z_in     = 8'd99;
    n = 0;
    while (!ov_a && n < 50) begin @(negedge clk); n++; end
    chk("get_timeout", 32'(n < 50), 1);
    if (stall > 0) out_ready = 1'b0;
    chk("sb_nonempty", 32'(qa.size() > 0 && qb.size() > 0), 1);
    if (qa.size() > 0 && qb.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("acc_a", acc_a, ea.acc);
      chk("ovf_a", ovf_a, ea.ovf);
      chk("acc_b", acc_b, eb.acc);
      chk("ovf_b", ovf_b, eb.ovf);
      chk("cnt_hold", cnt_a, LEN);
      chk("in_ready_hold", ir_a, 0);
      chk("out_valid_b", ov_b, 1);
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", ov_a, 1);
        chk("stall_acc", acc_a, ea.acc);
        chk("stall_ovf", ovf_a, ea.ovf);
        chk("stall_ready", ir_a, 0);
        chk("stall_cnt", cnt_a, LEN);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rel_valid", ov_a, 0);
    chk("rel_ready", ir_a, 1);
    chk("rel_cnt", cnt_a, 0);
    chk("rel_acc", acc_a, 0);
    chk("rel_ovf", ovf_a, 0);
    chk("rel_acc_b", acc_b, 0);
    chk("rel_ovf_b", ovf_b, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ir_a, 1);
    chk("rst_valid", ov_a, 0);
    chk("rst_acc", acc_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_ovf", ovf_a, 0);

    // Back-to-back 4 x 225: 900 at width 10, overflow at width 9.
    repeat (LEN) send(225, 0);
    get(0, 1'b0);

    // Gapped products 140, 0, 26, 225 -> 391.
    send(140, 1);
    send(0, 2);
    send(26, 3);
    send(225, 1);
    get(0, 1'b0);

    // Backpressure for 5 cycles with in_valid asserted during HOLD.
    repeat (LEN) send(225, 0);
    get(5, 1'b1);

    // Next group after an overflowed one: 4 x 1 -> 4, no overflow.
    repeat (LEN) send(1, 0);
    get(0, 1'b0);

    // Reset mid-group discards the partial sum.
    send(225, 0);
    send(225, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midrst_cnt", cnt_a, 0);
    chk("midrst_acc", acc_a, 0);
    chk("midrst_acc_b", acc_b, 0);
    repeat (LEN) send(10, 0);
    get(0, 1'b0);

    // Reset in HOLD together with out_ready.
    repeat (LEN) send(5, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold_before_rst", ov_a, 1);
    chk("hold_acc_before_rst", acc_a, 20);
    out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("holdrst_valid", ov_a, 0);
    chk("holdrst_ready", ir_a, 1);
    chk("holdrst_acc", acc_a, 0);
    chk("holdrst_cnt", cnt_a, 0);
    if (qa.size() > 0) void'(qa.pop_front());
    if (qb.size() > 0) void'(qb.pop_front());
    model_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_acc_unsigned.md
# mul_acc_unsigned

Downstream accumulation stage for the unsigned multiplier. It consumes the multiplier's `2*WIDTH`-bit product stream over a valid/ready handshake and sums exactly `LEN` consecutive products into one dot-product result. It presents that result on a held valid/ready output port and flags overflow. It sits directly after `mul_unsigned_for4`, whose `z` output drives `z_in`.

## Interface
- `WIDTH`, 4: multiplier operand width; product width is `2*WIDTH`.
- `LEN`, 4: number of products per result; legal range 2..255.
- `ACC_WIDTH`, 10: accumulator and result width; must be ≥ `2*WIDTH`.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: a product is present on `z_in`.
- `in_ready`  out  1: stage accepts a product this cycle.
- `z_in`  in  `2*WIDTH`: unsigned product from the multiplier.
- `out_valid`  out  1: `acc_out` holds a completed result.
- `out_ready`  in  1: consumer takes the result this cycle.
- `acc_out`  out  `ACC_WIDTH`: completed sum of `LEN` products.
- `ovf`  out  1: overflow occurred while forming the current result.
- `cnt`  out  8: number of products accepted into the group in progress.

## Operation
- Two states: ACCUM and HOLD.
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept: `in_valid && in_ready` at a rising edge. Each accept:
  - `acc <= acc + zero_ext(z_in)`.
  - `cnt <= cnt + 1`.
  - `ovf` becomes sticky-set if the true sum exceeds `2^ACC_WIDTH - 1`.
- When the accept brings `cnt` to `LEN`:
  - The state goes to HOLD.
  - `acc_out` and `ovf` are frozen.
  - `cnt` reads `LEN` while in HOLD.
- Release: `out_valid && out_ready` in HOLD. On release:
  - The state returns to ACCUM.
  - `acc`, `cnt` and `ovf` clear to 0.
- `acc_out` always shows the accumulator. It is only meaningful while `out_valid`=1.
- No input is lost. `in_ready` is 0 throughout HOLD, so the producer must stall.
- `in_valid` with `in_ready`=0 has no effect.
- `out_ready` while in ACCUM is ignored.
- Arithmetic is fully unsigned. Products are zero-extended to `ACC_WIDTH` before the add.
- Without saturation, the sum wraps modulo `2^ACC_WIDTH`.
- Reset:
  - State goes to ACCUM.
  - `acc_out`=0, `cnt`=0, `ovf`=0, `out_valid`=0.
  - `in_ready`=1 starting from the first cycle after reset.
  - Reset mid-group or during HOLD discards the partial or pending result.
  - `rst` has priority over a simultaneous accept or release.

## Timing
- `in_ready` and `out_valid` are decoded from registered state. There is no combinational path from `in_valid` or `out_ready` to any output.
- Latency: `out_valid` rises in the cycle after the `LEN`-th accept, with `acc_out` valid in that same cycle.
- Minimum period per result is `LEN`+1 cycles:
  - `LEN` accept cycles.
  - 1 HOLD cycle, when `out_ready` is held high.
- A release and the next accept cannot share a cycle. The first accept of the next group happens no earlier than the cycle after the release.
- `acc_out`, `ovf` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0, for an unbounded number of cycles.

## Configuration
- `MUL_ACC_SAT_EN` defined: on overflow the accumulator clamps to `2^ACC_WIDTH - 1` and stays there for the rest of the group. `ovf` is set as normal.
- `MUL_ACC_SAT_EN` undefined: the accumulator wraps modulo `2^ACC_WIDTH`. `ovf` is still set.
- Handshake, latency and `cnt` behaviour are identical in both builds.

## Test plan
- Reset, then 4 back-to-back accepts of 15·15=225 with `out_ready`=1 → `out_valid`=1 one cycle after the 4th accept, `acc_out`=900, `ovf`=0. `in_ready`=0 for exactly 1 cycle.
- Products 140, 0, 26, 225 with `in_valid` gaps of 1–3 cycles → `acc_out`=391. `cnt` steps 0,1,2,3 and shows 4 in HOLD.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result of 900 → `acc_out`=900 and `out_valid`=1 stable throughout. `in_valid`=1 during HOLD is not accepted. The release is followed by a new group that starts at 0.
- Overflow with `ACC_WIDTH`=9 and 4×225:
  - Without the macro → `acc_out`=388, `ovf`=1.
  - With `MUL_ACC_SAT_EN` → `acc_out`=511, `ovf`=1.
  - The next group of 4×1 → `acc_out`=4, `ovf`=0.
- `rst` pulsed after 2 accepts of 225, then 4 accepts of 10 → `acc_out`=40, `cnt` at most 4. No stale sum appears.
- `rst` asserted while in HOLD, in the same cycle as `out_ready` → next cycle `out_valid`=0, `in_ready`=1, `acc_out`=0.
